win_tally: RTL and testbench

WIN_TALLY -- requirements
Module: win_tally

---
 rtl/win_tally.sv | 114 +++++++++++
 tb/tb_win_tally.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_tally.sv
// win_tally: counts baccarat round outcomes as two-digit BCD tallies.
// A round is counted once per nonzero result, and only after the result has
// been seen at 00. The counted result is captured on entry to COUNT and
// committed on the edge that leaves COUNT, which also raises tally_pulse.
module win_tally (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       player_win_light,
    input  logic       dealer_win_light,
    input  logic       clear_tally,
    output logic [7:0] pwins,
    output logic [7:0] dwins,
    output logic [7:0] ties,
    output logic [1:0] last_result,
    output logic       tally_pulse,
    output logic       sat
);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [1:0] result;
    logic [1:0] pend;
    logic       count_en;
    logic       arm_load;

    assign result = {dealer_win_light, player_win_light};

    // Saturating two-digit BCD increment; 99 stays at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // State register; clear forces HOLD, discarding any round in flight.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)
            state <= HOLD;
        else if (clear_tally)
            state <= HOLD;
        else
            state <= state_nx;
    end

    // Next-state logic: wait for 00, then for a nonzero result, then count once.
    always_comb begin
        state_nx = state;
        unique case (state)
            HOLD:    if (result == 2'b00) state_nx = ARMED;
            ARMED:   if (result != 2'b00) state_nx = COUNT;
            COUNT:   state_nx = HOLD;
            default: state_nx = HOLD;
        endcase
    end

    // FSM outputs: capture the result on ARMED->COUNT, commit while in COUNT.
    always_comb begin
        count_en = (state == COUNT);
        arm_load = (state == ARMED) && (result != 2'b00);
    end

    // Holds the result that caused the transition into COUNT.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)
            pend <= '0;
        else if (clear_tally)
            pend <= '0;
        else if (arm_load)
            pend <= result;
    end

    // Tallies, last result and the registered one-cycle tally pulse.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            pwins       <= '0;
            dwins       <= '0;
            ties        <= '0;
            last_result <= '0;
            tally_pulse <= 1'b0;
        end else if (clear_tally) begin
            pwins       <= '0;
            dwins       <= '0;
            ties        <= '0;
            last_result <= '0;
            tally_pulse <= 1'b0;
        end else begin
            tally_pulse <= count_en;
            if (count_en) begin
                last_result <= pend;
                unique case (pend)
                    2'b01:   pwins <= bcd_inc(pwins);
                    2'b10:   dwins <= bcd_inc(dwins);
                    2'b11:   ties  <= bcd_inc(ties);
                    default: ;
                endcase
            end
        end
    end

    // Saturation flag straight from the registered counters.
    assign sat = (pwins == 8'h99) | (dwins == 8'h99) | (ties == 8'h99);

endmodule

// File: tb/tb_win_tally.sv
// tb_win_tally: randomized and directed checks of win_tally against a
// round-level reference model using integer counts.
module tb_win_tally;

    logic       clk;
    logic       resetb;
    logic       player;
    logic       dealer;
    logic       clr;
    logic [7:0] pwins;
    logic [7:0] dwins;
    logic [7:0] ties;
    logic [1:0] last_result;
    logic       tally_pulse;
    logic       sat;

    int checks = 0;
    int errors = 0;

    win_tally dut (
        .slow_clock      (clk),
        .resetb          (resetb),
        .player_win_light(player),
        .dealer_win_light(dealer),
        .clear_tally     (clr),
        .pwins           (pwins),
        .dwins           (dwins),
        .ties            (ties),
        .last_result     (last_result),
        .tally_pulse     (tally_pulse),
        .sat             (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer counts plus round-qualification flags.
    int         m_cnt [3];    // player, dealer, tie
    logic [1:0] m_last;
    logic       m_pulse;
    bit         m_need_zero;  // a 00 must be seen before the next round qualifies
    bit         m_commit;     // the next edge commits m_pend (its sample is ignored)
    logic [1:0] m_pend;

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    function automatic logic [27:0] exp_vec();
        logic s;
        s = (m_cnt[0] == 99) || (m_cnt[1] == 99) || (m_cnt[2] == 99);
        return {bcd(m_cnt[0]), bcd(m_cnt[1]), bcd(m_cnt[2]), m_last, m_pulse, s};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_last      = 2'b00;
        m_pulse     = 1'b0;
        m_need_zero = 1'b1;
        m_commit    = 1'b0;
        m_pend      = 2'b00;
    endtask

    task automatic model_edge(input logic [1:0] r, input logic c);
        if (c) begin
            model_reset();
        end else begin
            m_pulse = 1'b0;
            if (m_commit) begin
                if (m_cnt[m_pend - 1] < 99) m_cnt[m_pend - 1]++;
                m_last      = m_pend;
                m_pulse     = 1'b1;
                m_commit    = 1'b0;
                m_need_zero = 1'b1;
            end else if (m_need_zero) begin
                if (r == 2'b00) m_need_zero = 1'b0;
            end else if (r != 2'b00) begin
                m_commit = 1'b1;
                m_pend   = r;
            end
        end
    endtask

    // Apply inputs, take one rising edge, advance the model, settle 1 time unit.
    task automatic drive_cycle(input logic [1:0] r, input logic c);
        {dealer, player} = r;
        clr = c;
        @(posedge clk);
        model_edge(r, c);
        #1;
    endtask

    // Per-cycle invariants: BCD digits in range, tally_pulse never two cycles in a row.
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (resetb === 1'b1) begin
            checks++;
            if (pwins[3:0] > 9 || pwins[7:4] > 9 || dwins[3:0] > 9 || dwins[7:4] > 9 ||
                ties[3:0] > 9 || ties[7:4] > 9) begin
                errors++;
                $display("FAIL bcd_digits: got p=%h d=%h t=%h, each digit must be <= 9",
                         pwins, dwins, ties);
            end
            checks++;
            if (tally_pulse && prev_pulse) begin
                errors++;
                $display("FAIL pulse_width: got tally_pulse high 2 cycles, required 1");
            end
            prev_pulse = tally_pulse;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic test_reset();
        resetb = 1'b0; player = 1'b0; dealer = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({pwins, dwins, ties, last_result, tally_pulse, sat} !== 28'h0) begin
            errors++;
            $display("FAIL reset_state: got %h, required %h",
                     {pwins, dwins, ties, last_result, tally_pulse, sat}, 28'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic test_first_round();
        int pulses = 0;
        repeat (2) drive_cycle(2'b00, 1'b0);
        repeat (5) begin
            drive_cycle(2'b01, 1'b0);
            if (tally_pulse) pulses++;
            checks++;
            if ({pwins, dwins, ties, last_result, tally_pulse, sat} !== exp_vec()) begin
                errors++;
                $display("FAIL first_round_cycle: got %h, required %h",
                         {pwins, dwins, ties, last_result, tally_pulse, sat}, exp_vec());
            end
        end
        checks++;
        if (pwins !== 8'h01 || last_result !== 2'b01 || pulses != 1) begin
            errors++;
            $display("FAIL first_round: got pwins=%h last=%b pulses=%0d, required 01 01 1",
                     pwins, last_result, pulses);
        end
    endtask

    task automatic test_mixed();
        drive_cycle(2'b00, 1'b1);
        repeat (3) begin
            repeat (2) drive_cycle(2'b00, 1'b0);
            repeat (2) drive_cycle(2'b10, 1'b0);
        end
        repeat (2) drive_cycle(2'b00, 1'b0);
        repeat (2) drive_cycle(2'b11, 1'b0);
        drive_cycle(2'b00, 1'b0);
        checks++;
        if ({pwins, dwins, ties, last_result, tally_pulse, sat} !== exp_vec()) begin
            errors++;
            $display("FAIL mixed_model: got %h, required %h",
                     {pwins, dwins, ties, last_result, tally_pulse, sat}, exp_vec());
        end
        checks++;
        if (dwins !== 8'h03 || ties !== 8'h01 || pwins !== 8'h00 || last_result !== 2'b11) begin
            errors++;
            $display("FAIL mixed_counts: got d=%h t=%h p=%h last=%b, required 03 01 00 11",
                     dwins, ties, pwins, last_result);
        end
    endtask

    task automatic test_bcd_carry();
        drive_cycle(2'b00, 1'b1);
        for (int n = 1; n <= 100; n++) begin
            repeat (2) drive_cycle(2'b00, 1'b0);
            drive_cycle(2'b01, 1'b0);
            drive_cycle(2'b01, 1'b0);
            checks++;
            if ({pwins, dwins, ties, last_result, tally_pulse, sat} !== exp_vec()) begin
                errors++;
                $display("FAIL carry_round_%0d: got %h, required %h", n,
                         {pwins, dwins, ties, last_result, tally_pulse, sat}, exp_vec());
            end
            if (n == 10) begin
                checks++;
                if (pwins !== 8'h10 || sat !== 1'b0) begin
                    errors++;
                    $display("FAIL carry_ten: got pwins=%h sat=%b, required 10 0", pwins, sat);
                end
            end
            if (n == 99) begin
                checks++;
                if (pwins !== 8'h99 || sat !== 1'b1) begin
                    errors++;
                    $display("FAIL carry_99: got pwins=%h sat=%b, required 99 1", pwins, sat);
                end
            end
            if (n == 100) begin
                checks++;
                if (pwins !== 8'h99 || sat !== 1'b1 || tally_pulse !== 1'b1 || last_result !== 2'b01) begin
                    errors++;
                    $display("FAIL carry_saturate: got pwins=%h sat=%b pulse=%b last=%b, required 99 1 1 01",
                             pwins, sat, tally_pulse, last_result);
                end
            end
        end
    endtask

    task automatic test_hold();
        int pulses = 0;
        drive_cycle(2'b11, 1'b0);
        #2;
        resetb = 1'b0;
        model_reset();
        @(negedge clk);
        resetb = 1'b1;
        repeat (4) begin
            drive_cycle(2'b11, 1'b0);
            if (tally_pulse) pulses++;
        end
        checks++;
        if (ties !== 8'h00 || pwins !== 8'h00 || pulses != 0) begin
            errors++;
            $display("FAIL hold_no_count: got ties=%h pwins=%h pulses=%0d, required 00 00 0",
                     ties, pwins, pulses);
        end
        // result changing among nonzero values must not count either
        drive_cycle(2'b01, 1'b0);
        drive_cycle(2'b10, 1'b0);
        drive_cycle(2'b00, 1'b0);
        repeat (2) drive_cycle(2'b11, 1'b0);
        checks++;
        if ({pwins, dwins, ties, last_result, tally_pulse, sat} !== exp_vec() || ties !== 8'h01
            || dwins !== 8'h00 || pwins !== 8'h00) begin
            errors++;
            $display("FAIL hold_then_count: got %h, required %h with ties 01",
                     {pwins, dwins, ties, last_result, tally_pulse, sat}, exp_vec());
        end
    endtask

    task automatic test_clear();
        int pulses = 0;
        // clear on the ARMED->COUNT edge
        repeat (2) drive_cycle(2'b00, 1'b0);
        drive_cycle(2'b01, 1'b1);
        repeat (3) begin
            drive_cycle(2'b01, 1'b0);
            if (tally_pulse) pulses++;
        end
        checks++;
        if ({pwins, dwins, ties, last_result, tally_pulse} !== 27'h0 || pulses != 0) begin
            errors++;
            $display("FAIL clear_on_arm: got %h pulses=%0d, required 0 and 0",
                     {pwins, dwins, ties, last_result, tally_pulse}, pulses);
        end
        // count one round, then clear while in COUNT
        repeat (2) drive_cycle(2'b00, 1'b0);
        repeat (2) drive_cycle(2'b10, 1'b0);
        drive_cycle(2'b00, 1'b0);
        drive_cycle(2'b01, 1'b0);
        drive_cycle(2'b01, 1'b1);
        drive_cycle(2'b01, 1'b0);
        checks++;
        if ({pwins, dwins, ties, last_result, tally_pulse, sat} !== exp_vec() || dwins !== 8'h00
            || pwins !== 8'h00) begin
            errors++;
            $display("FAIL clear_in_count: got %h, required %h",
                     {pwins, dwins, ties, last_result, tally_pulse, sat}, exp_vec());
        end
        // count a round, then reset asynchronously while in COUNT
        repeat (2) drive_cycle(2'b00, 1'b0);
        repeat (2) drive_cycle(2'b11, 1'b0);
        drive_cycle(2'b00, 1'b0);
        drive_cycle(2'b10, 1'b0);
        #2;
        resetb = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({pwins, dwins, ties, last_result, tally_pulse, sat} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: got %h before next edge, required 0",
                     {pwins, dwins, ties, last_result, tally_pulse, sat});
        end
        @(negedge clk);
        resetb = 1'b1;
        repeat (3) drive_cycle(2'b10, 1'b0);
        checks++;
        if (dwins !== 8'h00 || tally_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: got dwins=%h pulse=%b, required 00 0", dwins, tally_pulse);
        end
    endtask

    task automatic test_random();
        logic [1:0] r;
        logic       c;
        drive_cycle(2'b00, 1'b1);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            c = ($urandom_range(0, 59) == 0);
            drive_cycle(r, c);
            checks++;
            if ({pwins, dwins, ties, last_result, tally_pulse, sat} !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h, required %h", i,
                         {pwins, dwins, ties, last_result, tally_pulse, sat}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_mixed();
        test_bcd_carry();
        test_hold();
        test_clear();
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
